prio_sel_arb: RTL and testbench
===============================

PRIO_SEL_ARB -- requirements
Module: prio_sel_arb

Interface
REQ-001 Parameter N_CH, default 4: number of request channels; legal range 2..16.
REQ-002 Parameter DW, default 8: data width per channel; legal range 1..64.
REQ-003 Parameter IW, default $clog2(N_CH): width of the grant index.
REQ-004 clk  input  1: single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 mode  input  1: 0 = fixed priority, 1 = round-robin.
REQ-007 req  input  N_CH: request from each channel; bit i is channel i.
REQ-008 din  input  N_CH*DW: channel data; channel i occupies bits [i*DW +: DW].
REQ-009 req_ack  output  N_CH: one-hot, combinational; marks the channel captured this cycle.
REQ-010 out_valid  output  1: output register holds a valid item.
REQ-011 out_ready  input  1: downstream accepts the item this cycle.
REQ-012 dout  output  DW: registered data of the granted channel.
REQ-013 gnt_idx  output  IW: registered index of the granted channel.
REQ-014 gnt_cnt  output  16: registered count of accepted output transfers.

Function
REQ-015 Capture condition: cap = (|req) & (~out_valid | out_ready).
REQ-016 On cap, the winner SHALL be chosen as follows:
- mode=0: the lowest-indexed asserted req wins (channel 0 highest priority).
- mode=1: the first asserted req at or above rr_ptr, scanning upward and wrapping modulo N_CH, wins.
REQ-017 req_ack SHALL be one-hot on the winner during a cap cycle and all-zero otherwise.
REQ-018 On cap, the block SHALL load the winner's slice into dout and its index into gnt_idx, and set out_valid on the next edge; latency from req to out_valid is 1 cycle.
REQ-019 If out_valid & out_ready and no req is asserted, out_valid SHALL clear on the next edge; dout and gnt_idx SHALL hold.
REQ-020 If out_valid & ~out_ready, dout, gnt_idx and out_valid SHALL hold and no channel is acked (backpressure).
REQ-021 Simultaneous drain and capture (out_valid & out_ready & cap) SHALL give back-to-back throughput: one item per cycle, with out_valid staying 1.
REQ-022 rr_ptr (internal, IW bits) SHALL update on every cap in mode=1 to winner+1, wrapping from N_CH-1 to 0.
REQ-023 rr_ptr SHALL not change in mode=0, and SHALL not change on cycles without cap.
REQ-024 A mode change SHALL take effect at the next cap, with no flush and no change to the held output.
REQ-025 gnt_cnt SHALL increment by 1 on each out_valid & out_ready cycle and saturate at 16'hFFFF.
REQ-026 req and din are sampled only on cap; din of non-winning channels is ignored.
REQ-027 When N_CH is not a power of 2, the rr_ptr wrap SHALL be at N_CH-1, never at 2^IW-1.

Reset
REQ-028 While rst is high: out_valid=0, dout=0, gnt_idx=0, gnt_cnt=0, rr_ptr=0, and req_ack is forced to 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held item; after release, the first cap behaves as a cold start with rr_ptr=0.

Structure
REQ-030 A shared package prio_sel_pkg SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the gnt_cnt width constant (16).
REQ-031 Winner selection SHALL be a separate combinational sub-module, prio_sel_pick.
- Inputs: req, base pointer, mode.
- Outputs: one-hot winner and its index.
- All registers live in the top module.

Verification
REQ-032 Fixed priority: mode=0, req=4'b1010, din ch1=8'h11, ch3=8'h33, out_ready=1 -> req_ack=4'b0010, next cycle dout=8'h11, gnt_idx=1.
REQ-033 Round-robin fairness: mode=1, req=4'b1111 held for 8 cycles, out_ready=1 -> gnt_idx sequence 0,1,2,3,0,1,2,3 and gnt_cnt=7 after the 8th capture.
REQ-034 Backpressure: item valid (gnt_idx=2), out_ready=0 for 3 cycles with req=4'b0001 -> dout and gnt_idx held and req_ack=0 throughout; out_ready=1 -> ch0 acked the same cycle and dout updates next cycle.
REQ-035 Wrap at non-power-of-2: N_CH=3, mode=1, req=3'b101 -> grants 0,2,0,2 and rr_ptr never reaches 3.
REQ-036 Reset mid-operation: rst pulse while out_valid=1 and rr_ptr=2 -> out_valid=0 and gnt_cnt=0 immediately (asynchronous); after release, with mode=1 and req=4'b1111, the first grant is ch0.
REQ-037 Saturation: preload gnt_cnt to 16'hFFFE, then 3 accepted transfers -> gnt_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/prio_sel_pkg.sv
// Shared constants for the priority/round-robin select arbiter.
package prio_sel_pkg;

  // Arbitration mode encodings
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of the accepted-transfer counter
  localparam int GNT_CNT_W = 16;

endpackage

// File: rtl/prio_sel_pick.sv
// Combinational winner selection.
// Scans upward from a base index, wrapping modulo N_CH. In fixed mode the base is forced to 0.
module prio_sel_pick
  import prio_sel_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   base_i,
  input  logic            mode_i,
  output logic [N_CH-1:0] win_oh_o,
  output logic [IW-1:0]   win_idx_o
);

  logic [IW-1:0] scan;
  logic          found;

  // First asserted request at or after the start point.
  // The scan index wraps at N_CH-1, not at the natural 2^IW boundary.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    scan      = (mode_i == MODE_RR) ? base_i : '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && req_i[scan]) begin
        found           = 1'b1;
        win_oh_o[scan]  = 1'b1;
        win_idx_o       = scan;
      end
      scan = (scan == IW'(N_CH - 1)) ? '0 : scan + 1'b1;
    end
  end

endmodule

// File: rtl/prio_sel_arb.sv
// N-channel arbiter with fixed-priority or round-robin selection, feeding a single
// registered output slot with valid/ready handshake and a saturating transfer counter.
module prio_sel_arb
  import prio_sel_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*DW-1:0]   din,
  output logic [N_CH-1:0]      req_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        dout,
  output logic [IW-1:0]        gnt_idx,
  output logic [GNT_CNT_W-1:0] gnt_cnt
);

  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [GNT_CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic [DW-1:0]   win_data;
  logic            cap;
  logic            drain;

  prio_sel_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .req_i     (req),
    .base_i    (rr_ptr_q),
    .mode_i    (mode),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // Capture whenever something is requesting and the output slot is free or draining.
  // Reset gates it so nothing is acked while rst is high.
  assign drain = out_valid_q & out_ready;
  assign cap   = (|req) & (~out_valid_q | out_ready) & ~rst;

  assign req_ack = cap ? win_oh : '0;

  // One-hot mux of the winning channel's data slice
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (win_oh[i]) win_data = win_data | din[i*DW +: DW];
    end
  end

  // Next state: drain clears the slot, a capture in the same cycle refills it
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_cnt_d   = gnt_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (drain) begin
      out_valid_d = 1'b0;
      if (gnt_cnt_q != '1) gnt_cnt_d = gnt_cnt_q + 1'b1;
    end
    if (cap) begin
      out_valid_d = 1'b1;
      dout_d      = win_data;
      gnt_idx_d   = win_idx;
      if (mode == MODE_RR)
        rr_ptr_d = (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      gnt_idx_q   <= '0;
      gnt_cnt_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_cnt_q   <= gnt_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_cnt   = gnt_cnt_q;

endmodule

// File: tb/tb_prio_sel_arb.sv
// Directed bench for prio_sel_arb: a 4-channel instance for the main scenarios and a
// 3-channel instance for the non-power-of-2 round-robin wrap.
module tb_prio_sel_arb;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode4, ordy4, ov4;
  logic [3:0]  req4, ack4;
  logic [31:0] din4;
  logic [7:0]  dout4;
  logic [1:0]  idx4;
  logic [15:0] cnt4;

  logic        mode3, ordy3, ov3;
  logic [2:0]  req3, ack3;
  logic [23:0] din3;
  logic [7:0]  dout3;
  logic [1:0]  idx3;
  logic [15:0] cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prio_sel_arb #(.N_CH(4), .DW(8)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .req(req4), .din(din4), .req_ack(ack4),
    .out_valid(ov4), .out_ready(ordy4), .dout(dout4), .gnt_idx(idx4), .gnt_cnt(cnt4)
  );

  prio_sel_arb #(.N_CH(3), .DW(8)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .req(req3), .din(din3), .req_ack(ack3),
    .out_valid(ov3), .out_ready(ordy3), .dout(dout3), .gnt_idx(idx3), .gnt_cnt(cnt3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    mode4 = 1'b0; req4 = 4'b1111; din4 = 32'h0; ordy4 = 1'b1;
    mode3 = 1'b0; req3 = 3'b111;  din3 = 24'h0; ordy3 = 1'b1;

    // Reset state, with requests asserted
    repeat (2) tick();
    chk("rst_ack4",  64'(ack4),  64'h0);
    chk("rst_ack3",  64'(ack3),  64'h0);
    chk("rst_ov",    64'(ov4),   64'h0);
    chk("rst_dout",  64'(dout4), 64'h0);
    chk("rst_idx",   64'(idx4),  64'h0);
    chk("rst_cnt",   64'(cnt4),  64'h0);

    rst = 1'b0; req3 = 3'b000;

    // Round-robin fairness with all channels requesting
    mode4 = 1'b1; req4 = 4'b1111; din4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; ordy4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_idx%0d", i),  64'(idx4),  64'(i % 4));
      chk($sformatf("rr_dout%0d", i), 64'(dout4), 64'(8'hA0 + 8'(i % 4)));
    end
    chk("rr_cnt7", 64'(cnt4), 64'd7);

    // Drain with no request: valid clears, data holds
    req4 = 4'b0000;
    tick();
    chk("drain_ov",   64'(ov4),   64'h0);
    chk("drain_cnt",  64'(cnt4),  64'd8);
    chk("drain_dout", 64'(dout4), 64'hA3);
    chk("drain_idx",  64'(idx4),  64'd3);

    // Fixed priority, lowest index wins
    mode4 = 1'b0; req4 = 4'b1010; din4 = {8'h33, 8'h00, 8'h11, 8'h00};
    #1;
    chk("fix_ack", 64'(ack4), 64'b0010);
    tick();
    chk("fix_dout", 64'(dout4), 64'h11);
    chk("fix_idx",  64'(idx4),  64'd1);
    chk("fix_ov",   64'(ov4),   64'h1);

    // Load channel 2 back-to-back
    req4 = 4'b0100; din4 = {8'h33, 8'h77, 8'h11, 8'h5A};
    #1;
    chk("b2b_ack", 64'(ack4), 64'b0100);
    tick();
    chk("b2b_idx", 64'(idx4), 64'd2);
    chk("b2b_ov",  64'(ov4),  64'h1);
    chk("b2b_cnt", 64'(cnt4), 64'd9);

    // Backpressure for 3 cycles
    ordy4 = 1'b0; req4 = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ack%0d", i), 64'(ack4), 64'h0);
      tick();
      chk($sformatf("bp_dout%0d", i), 64'(dout4), 64'h77);
      chk($sformatf("bp_idx%0d", i),  64'(idx4),  64'd2);
      chk($sformatf("bp_ov%0d", i),   64'(ov4),   64'h1);
    end
    ordy4 = 1'b1;
    #1;
    chk("bp_rel_ack", 64'(ack4), 64'b0001);
    tick();
    chk("bp_rel_dout", 64'(dout4), 64'h5A);
    chk("bp_rel_idx",  64'(idx4),  64'd0);
    chk("bp_rel_cnt",  64'(cnt4),  64'd10);

    req4 = 4'b0000;
    tick();
    chk("idle_ov",  64'(ov4),  64'h0);
    chk("idle_cnt", 64'(cnt4), 64'd11);

    // Back to round-robin: pointer must not have moved during fixed-mode grants
    mode4 = 1'b1; req4 = 4'b1111; din4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    chk("rr2_ack", 64'(ack4), 64'b0001);
    tick();
    chk("rr2_idx0", 64'(idx4), 64'd0);
    tick();
    chk("rr2_idx1", 64'(idx4), 64'd1);
    chk("rr2_cnt",  64'(cnt4), 64'd12);

    // Asynchronous reset mid-transfer (item valid, pointer at 2)
    ordy4 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov",   64'(ov4),   64'h0);
    chk("arst_cnt",  64'(cnt4),  64'h0);
    chk("arst_dout", 64'(dout4), 64'h0);
    chk("arst_ack",  64'(ack4),  64'h0);
    tick();
    rst = 1'b0; ordy4 = 1'b1;
    #1;
    chk("cold_ack", 64'(ack4), 64'b0001);
    tick();
    chk("cold_idx",  64'(idx4),  64'd0);
    chk("cold_dout", 64'(dout4), 64'hA0);

    // Non-power-of-2 wrap on the 3-channel instance
    req4 = 4'b0000;
    mode3 = 1'b1; req3 = 3'b101; din3 = {8'hC2, 8'hC1, 8'hC0}; ordy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("n3_idx%0d", i), 64'(idx3), (i % 2 == 0) ? 64'd0 : 64'd2);
      chk($sformatf("n3_ptr%0d", i), 64'(u_dut3.rr_ptr_q), (i % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Saturation: 4-channel instance is idle with count 1
    chk("sat_pre", 64'(cnt4), 64'd1);
    mode4 = 1'b0; req4 = 4'b0001; ordy4 = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", 64'(cnt4), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_ffff%0d", i), 64'(cnt4), 64'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
